pipe_ctrl_unit: RTL and testbench

- Next-generation control unit for the 5-stage RISC-V pipeline.
- Decodes the instruction in Decode (D) and carries control signals through internal E/M/W pipeline registers.
- Resolves branches and jumps in Execute (E) using full ALU flags and generates the redirect.
- Adds over the single-cycle controller: bne/blt/bge/bltu/bgeu, jalr, lui, illegal-op detection, bubble insertion on flush, and a parametrised ALU-control width.

---
 rtl/pipe_ctrl_unit.sv | 269 ++++++++++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// Pipelined RISC-V control unit: decode in D, control carried through E/M/W registers,
// branch/jump redirect resolved in E. Optional saturating redirect counter: PIPE_CTRL_REDIRECT_CNT_EN.
module pipe_ctrl_unit #(
    parameter int unsigned ALUCTRL_W = 4,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opD,
    input  logic [2:0]           funct3D,
    input  logic                 funct7b5D,
    input  logic                 FlushE,
    input  logic                 ZeroE,
    input  logic                 NegE,
    input  logic                 CarryE,
    input  logic                 OvfE,
    output logic [2:0]           ImmSrcD,
    output logic                 IllegalD,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 ALUSrcE,
    output logic                 ResultSrcE0,
    output logic                 PCSrcE,
    output logic                 PCTargetSrcE,
    output logic                 RegWriteM,
    output logic                 MemWriteM,
    output logic                 RegWriteW,
    output logic [1:0]           ResultSrcW
`ifdef PIPE_CTRL_REDIRECT_CNT_EN
    ,
    output logic [CNT_W-1:0]     RedirectCnt
`endif
);

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_RTYPE  = 7'b0110011,
        OP_ITYPE  = 7'b0010011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_LUI    = 7'b0110111
    } opcode_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } result_src_e;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } branch_f3_e;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       jump_reg;
        logic       branch;
        logic [3:0] alu_op;
        logic       alu_src;
        logic [2:0] funct3;
    } ex_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
    } mem_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
    } wb_ctrl_t;

    if (ALUCTRL_W < 4) begin : g_aluctrl_w_check
        $error("pipe_ctrl_unit: ALUCTRL_W must be at least 4");
    end
    if (CNT_W < 1) begin : g_cnt_w_check
        $error("pipe_ctrl_unit: CNT_W must be at least 1");
    end

    alu_op_e   arith_op;
    imm_src_e  imm_src;
    logic      illegal;
    ex_ctrl_t  dec_ctrl;
    ex_ctrl_t  e_ctrl_d, e_ctrl_q;
    mem_ctrl_t m_ctrl_d, m_ctrl_q;
    wb_ctrl_t  w_ctrl_d, w_ctrl_q;
    logic      branch_cond;

    // Shared R/I arithmetic decode; only R-type may select sub, funct7b5 picks sra in both.
    always_comb begin : arith_decode
        arith_op = ALU_ADD;
        case (funct3D)
            3'b000:  arith_op = (opD == OP_RTYPE && funct7b5D) ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_SLT;
            3'b011:  arith_op = ALU_SLTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = funct7b5D ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    end

    always_comb begin : main_decode
        dec_ctrl            = '0;
        dec_ctrl.funct3     = funct3D;
        dec_ctrl.alu_op     = ALU_ADD;
        dec_ctrl.result_src = RES_ALU;
        imm_src             = IMM_I;
        illegal             = 1'b0;
        case (opD)
            OP_LOAD: begin
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.alu_src    = 1'b1;
                dec_ctrl.result_src = RES_MEM;
            end
            OP_STORE: begin
                dec_ctrl.mem_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                imm_src            = IMM_S;
            end
            OP_RTYPE: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_op    = arith_op;
            end
            OP_ITYPE: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_op    = arith_op;
            end
            OP_BRANCH: begin
                dec_ctrl.branch = 1'b1;
                dec_ctrl.alu_op = ALU_SUB;
                imm_src         = IMM_B;
                illegal         = (funct3D[2:1] == 2'b01);
            end
            OP_JAL: begin
                dec_ctrl.jump       = 1'b1;
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.result_src = RES_PC4;
                imm_src             = IMM_J;
            end
            OP_JALR: begin
                dec_ctrl.jump       = 1'b1;
                dec_ctrl.jump_reg   = 1'b1;
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.alu_src    = 1'b1;
                dec_ctrl.result_src = RES_PC4;
            end
            OP_LUI: begin
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.result_src = RES_IMM;
                imm_src             = IMM_U;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    assign ImmSrcD  = imm_src;
    assign IllegalD = illegal;

    always_comb begin : stage_next
        e_ctrl_d = dec_ctrl;
        if (FlushE) begin
            e_ctrl_d = '0;
        end
        m_ctrl_d.reg_write  = e_ctrl_q.reg_write;
        m_ctrl_d.result_src = e_ctrl_q.result_src;
        m_ctrl_d.mem_write  = e_ctrl_q.mem_write;
        w_ctrl_d.reg_write  = m_ctrl_q.reg_write;
        w_ctrl_d.result_src = m_ctrl_q.result_src;
    end

    always_ff @(posedge clk or posedge reset) begin : stage_regs
        if (reset) begin
            e_ctrl_q <= '0;
            m_ctrl_q <= '0;
            w_ctrl_q <= '0;
        end else begin
            e_ctrl_q <= e_ctrl_d;
            m_ctrl_q <= m_ctrl_d;
            w_ctrl_q <= w_ctrl_d;
        end
    end

    // Flags come from a-b; reserved funct3 codes never take.
    always_comb begin : branch_resolve
        branch_cond = 1'b0;
        case (e_ctrl_q.funct3)
            F3_BEQ:  branch_cond = ZeroE;
            F3_BNE:  branch_cond = ~ZeroE;
            F3_BLT:  branch_cond = NegE ^ OvfE;
            F3_BGE:  branch_cond = ~(NegE ^ OvfE);
            F3_BLTU: branch_cond = ~CarryE;
            F3_BGEU: branch_cond = CarryE;
            default: branch_cond = 1'b0;
        endcase
        PCSrcE = (e_ctrl_q.branch & branch_cond) | e_ctrl_q.jump;
    end

    always_comb begin : alu_ctrl_out
        ALUControlE      = '0;
        ALUControlE[3:0] = e_ctrl_q.alu_op;
    end

    assign ALUSrcE      = e_ctrl_q.alu_src;
    assign ResultSrcE0  = e_ctrl_q.result_src[0];
    assign PCTargetSrcE = e_ctrl_q.jump_reg;
    assign RegWriteM    = m_ctrl_q.reg_write;
    assign MemWriteM    = m_ctrl_q.mem_write;
    assign RegWriteW    = w_ctrl_q.reg_write;
    assign ResultSrcW   = w_ctrl_q.result_src;

`ifdef PIPE_CTRL_REDIRECT_CNT_EN
    logic [CNT_W-1:0] redirect_cnt_d, redirect_cnt_q;

    always_comb begin : redirect_cnt_next
        redirect_cnt_d = redirect_cnt_q;
        if (PCSrcE && (redirect_cnt_q != '1)) begin
            redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin : redirect_cnt_reg
        if (reset) begin
            redirect_cnt_q <= '0;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign RedirectCnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed vectors, hand sequences, and a randomized
// run against a behavioural pipeline model.
module tb_pipe_ctrl_unit;

`ifdef PIPE_CTRL_REDIRECT_CNT_EN
    localparam int unsigned TB_CNT_W = 2;
`else
    localparam int unsigned TB_CNT_W = 32;
`endif

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic [6:0] opD       = 7'b1111111;
    logic [2:0] funct3D   = '0;
    logic       funct7b5D = 1'b0;
    logic       FlushE    = 1'b0;
    logic       ZeroE     = 1'b0;
    logic       NegE      = 1'b0;
    logic       CarryE    = 1'b0;
    logic       OvfE      = 1'b0;
    logic [2:0] ImmSrcD;
    logic       IllegalD;
    logic [3:0] ALUControlE;
    logic       ALUSrcE;
    logic       ResultSrcE0;
    logic       PCSrcE;
    logic       PCTargetSrcE;
    logic       RegWriteM;
    logic       MemWriteM;
    logic       RegWriteW;
    logic [1:0] ResultSrcW;
`ifdef PIPE_CTRL_REDIRECT_CNT_EN
    logic [TB_CNT_W-1:0] RedirectCnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(
        .ALUCTRL_W(4),
        .CNT_W    (TB_CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .opD         (opD),
        .funct3D     (funct3D),
        .funct7b5D   (funct7b5D),
        .FlushE      (FlushE),
        .ZeroE       (ZeroE),
        .NegE        (NegE),
        .CarryE      (CarryE),
        .OvfE        (OvfE),
        .ImmSrcD     (ImmSrcD),
        .IllegalD    (IllegalD),
        .ALUControlE (ALUControlE),
        .ALUSrcE     (ALUSrcE),
        .ResultSrcE0 (ResultSrcE0),
        .PCSrcE      (PCSrcE),
        .PCTargetSrcE(PCTargetSrcE),
        .RegWriteM   (RegWriteM),
        .MemWriteM   (MemWriteM),
        .RegWriteW   (RegWriteW),
        .ResultSrcW  (ResultSrcW)
`ifdef PIPE_CTRL_REDIRECT_CNT_EN
        ,
        .RedirectCnt (RedirectCnt)
`endif
    );

    // Expected control word for one instruction, derived from the instruction-set rules.
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic [1:0] result_src;
        logic [3:0] alu;
        logic       alu_known;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic       jump_reg;
        logic [2:0] f3;
        logic [2:0] imm;
        logic       imm_known;
        logic       illegal;
    } ref_t;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       fl;
        logic       z;
        logic       n;
        logic       c;
        logic       o;
        logic       chk_imm;
        logic [2:0] imm;
        logic       ill;
        logic       chk_alu;
        logic [3:0] alu;
        logic       pc;
        logic       tgt;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic ref_t ref_bubble();
        ref_t r;
        r           = '0;
        r.alu_known = 1'b1;
        return r;
    endfunction

    function automatic ref_t ref_decode(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        ref_t       r;
        logic [3:0] by_f3 [8];
        by_f3       = '{4'h0, 4'h7, 4'h5, 4'h6, 4'h4, 4'h8, 4'h3, 4'h2};
        r           = '0;
        r.f3        = f3;
        r.alu_known = 1'b1;
        r.imm_known = 1'b1;
        case (op)
            7'b0000011: begin r.reg_write = 1; r.alu_src = 1; r.result_src = 2'b01; end
            7'b0100011: begin r.mem_write = 1; r.alu_src = 1; r.imm = 3'b001; end
            7'b0110011: begin
                r.reg_write = 1; r.imm_known = 0; r.alu = by_f3[f3];
                if (f3 == 3'd0 && f7) r.alu = 4'h1;
                if (f3 == 3'd5 && f7) r.alu = 4'h9;
            end
            7'b0010011: begin
                r.reg_write = 1; r.alu_src = 1; r.alu = by_f3[f3];
                if (f3 == 3'd5 && f7) r.alu = 4'h9;
            end
            7'b1100011: begin
                r.branch = 1; r.alu = 4'h1; r.imm = 3'b010;
                r.illegal = (f3 == 3'd2 || f3 == 3'd3);
            end
            7'b1101111: begin
                r.jump = 1; r.reg_write = 1; r.result_src = 2'b10; r.imm = 3'b011; r.alu_known = 0;
            end
            7'b1100111: begin
                r.jump = 1; r.jump_reg = 1; r.reg_write = 1; r.alu_src = 1; r.result_src = 2'b10;
            end
            7'b0110111: begin
                r.reg_write = 1; r.result_src = 2'b11; r.imm = 3'b100; r.alu_known = 0;
            end
            default: begin r.illegal = 1; r.imm_known = 0; r.alu_known = 0; end
        endcase
        return r;
    endfunction

    function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive_ab(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] diff;
        diff   = a - b;
        ZeroE  = (diff == 32'd0);
        NegE   = diff[31];
        CarryE = (a >= b);
        OvfE   = (a[31] != b[31]) && (diff[31] != a[31]);
    endtask

    task automatic drive_d(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic fl);
        opD       = op;
        funct3D   = f3;
        funct7b5D = f7;
        FlushE    = fl;
    endtask

    function automatic logic [6:0] pick_op(input int unsigned k);
        case (k)
            0:       return 7'b0000011;
            1:       return 7'b0100011;
            2:       return 7'b0110011;
            3:       return 7'b0010011;
            4:       return 7'b1100011;
            5:       return 7'b1101111;
            6:       return 7'b1100111;
            7:       return 7'b0110111;
            8:       return 7'b1111111;
            default: return 7'($urandom);
        endcase
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t        vecs[$];
        ref_t        pe, pm, pw, dexp;
        logic [31:0] a, b;
        logic        exp_pc;

        // Reset state, then R-type sub flowing through E/M/W.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pcsrc", PCSrcE, 0);
        check("rst_alu", ALUControlE, 0);
        check("rst_regwm", RegWriteM, 0);
        check("rst_memwm", MemWriteM, 0);
        check("rst_regww", RegWriteW, 0);
        check("rst_ressrcw", ResultSrcW, 0);
        check("rst_tgt", PCTargetSrcE, 0);
        reset = 1'b0;
        drive_d(7'b0110011, 3'b000, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive_d(7'b1111111, 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        check("sub_aluE", ALUControlE, 4'b0001);
        check("sub_regwm_early", RegWriteM, 0);
        @(negedge clk);
        check("sub_regwm", RegWriteM, 1);
        @(negedge clk);
        check("sub_regww", RegWriteW, 1);
        check("sub_ressrcw", ResultSrcW, 2'b00);

        // Store: memory write in M, no register write in W.
        drive_d(7'b0100011, 3'b010, 1'b0, 1'b0);
        #1 check("sw_immD", ImmSrcD, 3'b001);
        @(posedge clk); #1;
        drive_d(7'b1111111, 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("sw_memwm", MemWriteM, 1);
        check("sw_regwm", RegWriteM, 0);
        @(negedge clk);
        check("sw_regww", RegWriteW, 0);

        // jalr: redirect to ALU target, PC+4 written back.
        drive_d(7'b1100111, 3'b000, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive_d(7'b1111111, 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        check("jalr_pcsrc", PCSrcE, 1);
        check("jalr_tgt", PCTargetSrcE, 1);
        @(negedge clk);
        check("jalr_regwm", RegWriteM, 1);
        @(negedge clk);
        check("jalr_regww", RegWriteW, 1);
        check("jalr_ressrcw", ResultSrcW, 2'b10);

        // jal flushed on entry to E becomes a bubble.
        drive_d(7'b1101111, 3'b000, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive_d(7'b1111111, 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        check("jalfl_pcsrc", PCSrcE, 0);
        @(negedge clk);
        check("jalfl_regwm", RegWriteM, 0);
        @(negedge clk);
        check("jalfl_regww", RegWriteW, 0);

        // Illegal opcode: flagged in D, nothing written later.
        drive_d(7'b1111111, 3'b000, 1'b0, 1'b0);
        #1 check("ill_flag", IllegalD, 1);
        @(negedge clk);
        check("ill_pcsrc", PCSrcE, 0);
        @(negedge clk);
        check("ill_regwm", RegWriteM, 0);
        check("ill_memwm", MemWriteM, 0);
        @(negedge clk);
        check("ill_regww", RegWriteW, 0);

`ifdef PIPE_CTRL_REDIRECT_CNT_EN
        reset = 1'b1;
        #1 check("cnt_rst", RedirectCnt, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_d(7'b1101111, 3'b000, 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        drive_d(7'b1111111, 3'b000, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("cnt_sat", RedirectCnt, 2'b11);
`endif

        // Mid-stream asynchronous reset: lw in W, sw in M, then reset without a clock edge.
        @(negedge clk);
        drive_d(7'b0000011, 3'b010, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive_d(7'b0100011, 3'b010, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive_d(7'b0000011, 3'b010, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("mid_pre_regww", RegWriteW, 1);
        check("mid_pre_memwm", MemWriteM, 1);
        check("mid_pre_ressrcw", ResultSrcW, 2'b01);
        #1 reset = 1'b1;
        #1;
        check("mid_regww", RegWriteW, 0);
        check("mid_memwm", MemWriteM, 0);
        check("mid_regwm", RegWriteM, 0);
        check("mid_ressrcw", ResultSrcW, 0);
        check("mid_src0", ResultSrcE0, 0);
`ifdef PIPE_CTRL_REDIRECT_CNT_EN
        check("mid_cnt", RedirectCnt, 0);
`endif
        @(negedge clk);
        reset = 1'b0;
        drive_d(7'b1111111, 3'b000, 1'b0, 1'b0);
        @(negedge clk);

        // Directed vectors: op, f3, f7, flush, Z, N, C, V, chk_imm, imm, illegal, chk_alu, alu, pcsrc, tgt
        vecs.push_back('{7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 3'd0, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0});
        vecs.push_back('{7'b0110011, 3'b101, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 3'd0, 1'b0, 1'b1, 4'h9, 1'b0, 1'b0});
        vecs.push_back('{7'b0110011, 3'b011, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 3'd0, 1'b0, 1'b1, 4'h6, 1'b0, 1'b0});
        vecs.push_back('{7'b0110011, 3'b111, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 3'd0, 1'b0, 1'b1, 4'h2, 1'b0, 1'b0});
        vecs.push_back('{7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0, 0, 0, 1'b1, 3'd0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0});
        vecs.push_back('{7'b0010011, 3'b101, 1'b1, 1'b0, 0, 0, 0, 0, 1'b1, 3'd0, 1'b0, 1'b1, 4'h9, 1'b0, 1'b0});
        vecs.push_back('{7'b0010011, 3'b101, 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 3'd0, 1'b0, 1'b1, 4'h8, 1'b0, 1'b0});
        vecs.push_back('{7'b0010011, 3'b110, 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 3'd0, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0});
        vecs.push_back('{7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 3'd0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0});
        vecs.push_back('{7'b0100011, 3'b010, 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 3'd1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0});
        vecs.push_back('{7'b1100011, 3'b000, 1'b0, 1'b0, 1, 0, 1, 0, 1'b1, 3'd2, 1'b0, 1'b1, 4'h1, 1'b1, 1'b0});
        vecs.push_back('{7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 3'd2, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0});
        vecs.push_back('{7'b1100011, 3'b001, 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 3'd2, 1'b0, 1'b1, 4'h1, 1'b1, 1'b0});
        vecs.push_back('{7'b1100011, 3'b100, 1'b0, 1'b0, 0, 1, 0, 1, 1'b1, 3'd2, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0});
        vecs.push_back('{7'b1100011, 3'b100, 1'b0, 1'b0, 0, 1, 0, 0, 1'b1, 3'd2, 1'b0, 1'b1, 4'h1, 1'b1, 1'b0});
        vecs.push_back('{7'b1100011, 3'b101, 1'b0, 1'b0, 0, 1, 0, 0, 1'b1, 3'd2, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0});
        vecs.push_back('{7'b1100011, 3'b110, 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 3'd2, 1'b0, 1'b1, 4'h1, 1'b1, 1'b0});
        vecs.push_back('{7'b1100011, 3'b111, 1'b0, 1'b0, 0, 0, 1, 0, 1'b1, 3'd2, 1'b0, 1'b1, 4'h1, 1'b1, 1'b0});
        vecs.push_back('{7'b1100011, 3'b111, 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 3'd2, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0});
        vecs.push_back('{7'b1100011, 3'b010, 1'b0, 1'b0, 1, 0, 1, 0, 1'b1, 3'd2, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0});
        vecs.push_back('{7'b1100111, 3'b000, 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 3'd0, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1});
        vecs.push_back('{7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 3'd3, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0});
        vecs.push_back('{7'b0110111, 3'b000, 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 3'd4, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0});
        vecs.push_back('{7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 3'd0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0});
        vecs.push_back('{7'b1101111, 3'b000, 1'b0, 1'b1, 0, 0, 0, 0, 1'b1, 3'd3, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0});
        vecs.push_back('{7'b1100111, 3'b000, 1'b0, 1'b1, 0, 0, 0, 0, 1'b1, 3'd0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0});
        vecs.push_back('{7'b1100011, 3'b001, 1'b0, 1'b1, 0, 0, 0, 0, 1'b1, 3'd2, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0});

        foreach (vecs[i]) begin
            drive_d(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].fl);
            #1;
            check($sformatf("vec%0d_ill", i), IllegalD, vecs[i].ill);
            if (vecs[i].chk_imm) check($sformatf("vec%0d_imm", i), ImmSrcD, vecs[i].imm);
            @(posedge clk); #1;
            ZeroE  = vecs[i].z;
            NegE   = vecs[i].n;
            CarryE = vecs[i].c;
            OvfE   = vecs[i].o;
            FlushE = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d_pcsrc", i), PCSrcE, vecs[i].pc);
            check($sformatf("vec%0d_tgt", i), PCTargetSrcE, vecs[i].tgt);
            if (vecs[i].chk_alu) check($sformatf("vec%0d_alu", i), ALUControlE, vecs[i].alu);
        end

        // Randomized run against the pipeline model.
        reset = 1'b1;
        drive_d(7'b1111111, 3'b000, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        pe = ref_bubble();
        pm = ref_bubble();
        pw = ref_bubble();
        drive_d(pick_op($urandom_range(0, 9)), 3'($urandom), 1'($urandom), 1'b0);
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(posedge clk); #1;
            pw = pm;
            pm = pe;
            pe = FlushE ? ref_bubble() : ref_decode(opD, funct3D, funct7b5D);
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = $urandom;
                2:       b = a ^ 32'h8000_0000;
                default: b = a + 32'd1;
            endcase
            drive_ab(a, b);
            exp_pc = (pe.branch && ref_taken(pe.f3, a, b)) || pe.jump;
            drive_d(pick_op($urandom_range(0, 9)), 3'($urandom), 1'($urandom),
                    ($urandom_range(0, 7) == 0));
            dexp = ref_decode(opD, funct3D, funct7b5D);
            @(negedge clk);
            check("rnd_illD", IllegalD, dexp.illegal);
            if (dexp.imm_known) check("rnd_immD", ImmSrcD, dexp.imm);
            if (pe.alu_known) begin
                check("rnd_aluE", ALUControlE, pe.alu);
                check("rnd_alusrcE", ALUSrcE, pe.alu_src);
            end
            check("rnd_src0E", ResultSrcE0, pe.result_src[0]);
            check("rnd_pcsrcE", PCSrcE, exp_pc);
            check("rnd_tgtE", PCTargetSrcE, pe.jump_reg);
            check("rnd_regwM", RegWriteM, pm.reg_write);
            check("rnd_memwM", MemWriteM, pm.mem_write);
            check("rnd_regwW", RegWriteW, pw.reg_write);
            check("rnd_ressrcW", ResultSrcW, pw.result_src);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
